// File: rtl/sub_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sub_pipe_pkg : shared types and helpers for the pipelined subtractor|
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
package sub_pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;

  typedef struct packed {
    logic                 valid;
    logic                 borrow;
    logic [WIDTH_DEF-1:0] diff;
    logic [WIDTH_DEF-1:0] rem_a;
    logic [WIDTH_DEF-1:0] rem_b;
  } stage_t;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unsigned_32_bit_subtractor_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | unsigned_32_bit_subtractor_pipe_if : operand/result stream bundle   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
interface unsigned_32_bit_subtractor_pipe_if
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, in1, in2, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, in1, in2, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );

endinterface
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sub_chunk : combinational CHUNK-bit ripple-borrow subtractor slice  |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             b_in,
  output logic [CHUNK-1:0] d,
  output logic             b_out
);

  logic w_borrow;

  always_comb begin
    d        = '0;
    w_borrow = b_in;
    for (int i = 0; i < CHUNK; i++) begin
      d[i]     = a[i] ^ b[i] ^ w_borrow;
      w_borrow = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow);
    end
    b_out = w_borrow;
  end

endmodule
`default_nettype wire

// File: rtl/unsigned_32_bit_subtractor_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | unsigned_32_bit_subtractor_pipe : CHUNK-sliced pipelined a-b-bin    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module unsigned_32_bit_subtractor_pipe
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic clk,
  input  logic rst,
  unsigned_32_bit_subtractor_pipe_if.slave bus
);

  // WIDTH must be a multiple of CHUNK; each stage resolves one slice.
  localparam int STAGES = num_stages(WIDTH, CHUNK);

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_borrow;
  logic [WIDTH-1:0]  w_diff  [STAGES];
  logic [WIDTH-1:0]  w_src_a [STAGES];
  logic [WIDTH-1:0]  w_src_b [STAGES];
  logic [STAGES:0]   w_adv;
  logic              w_zero;

  assign w_src_a[0] = bus.in1;
  assign w_src_b[0] = bus.in2;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = !w_valid[k] || w_adv[k+1];
    end
  end

  assign bus.in_ready = w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_v_in;
    logic             w_b_in;
    logic [WIDTH-1:0] w_d_in;
    logic [WIDTH-1:0] w_d_next;
    logic [CHUNK-1:0] w_slice_d;
    logic             w_slice_b;
    logic             r_valid;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff;

    if (k == 0) begin : g_first
      assign w_v_in = bus.in_valid;
      assign w_b_in = bus.bin;
      assign w_d_in = '0;
    end else begin : g_next
      assign w_v_in = w_valid[k-1];
      assign w_b_in = w_borrow[k-1];
      assign w_d_in = w_diff[k-1];
    end

    sub_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a     (w_src_a[k][CHUNK-1:0]),
      .b     (w_src_b[k][CHUNK-1:0]),
      .b_in  (w_b_in),
      .d     (w_slice_d),
      .b_out (w_slice_b)
    );

    always_comb begin
      w_d_next                    = w_d_in;
      w_d_next[k*CHUNK +: CHUNK]  = w_slice_d;
    end

    // Payload only moves with a real operand so a stalled result stays put.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid  <= 1'b0;
        r_borrow <= 1'b0;
        r_diff   <= '0;
      end else if (w_adv[k]) begin
        r_valid <= w_v_in;
        if (w_v_in) begin
          r_borrow <= w_slice_b;
          r_diff   <= w_d_next;
        end
      end
    end

    assign w_valid[k]  = r_valid;
    assign w_borrow[k] = r_borrow;
    assign w_diff[k]   = r_diff;

    if (k == STAGES - 1) begin : g_last
      logic r_zero;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_zero <= 1'b0;
        end else if (w_adv[k] && w_v_in) begin
          r_zero <= (w_d_next == '0);
        end
      end

      assign w_zero = r_zero;
    end else begin : g_carry
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      // Remaining operand slices are kept right-aligned for the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv[k] && w_v_in) begin
          r_a <= w_src_a[k] >> CHUNK;
          r_b <= w_src_b[k] >> CHUNK;
        end
      end

      assign w_src_a[k+1] = r_a;
      assign w_src_b[k+1] = r_b;
    end
  end

  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.diff      = w_diff[STAGES-1];
  assign bus.bout      = w_borrow[STAGES-1];
  assign bus.zero      = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_32_bit_subtractor_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_unsigned_32_bit_subtractor_pipe : directed table + random stream |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_unsigned_32_bit_subtractor_pipe;

  localparam int N_RAND = 20000;

  logic clk;
  logic rst;

  unsigned_32_bit_subtractor_pipe_if #(.WIDTH(32)) bus ();

  unsigned_32_bit_subtractor_pipe #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bo;
    logic        z;
  } vec_t;

  vec_t        vecs [9];
  logic [33:0] q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_d;
  logic        last_bo;
  logic        last_z;
  logic        s_in_ready;
  logic        s_out_valid;

  // Reference result {bout, zero, diff} from plain wide arithmetic.
  function automatic logic [33:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic bin);
    logic [32:0] t;
    t = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    return {t[32], (t[31:0] == 32'd0), t[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; ends on the next falling edge.
  task automatic step(output logic in_fire, output logic out_fire);
    #1;
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    in_fire     = bus.in_valid && bus.in_ready && !rst;
    out_fire    = bus.out_valid && bus.out_ready && !rst;
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got diff %h with no pending operand", bus.diff);
        end else begin
          check("result", {30'd0, bus.bout, bus.zero, bus.diff}, {30'd0, q[0]});
        end
        if (out_fire) begin
          last_d  = bus.diff;
          last_bo = bus.bout;
          last_z  = bus.zero;
          if (q.size() != 0) void'(q.pop_front());
        end
      end
      if (in_fire) q.push_back(ref_res(bus.in1, bus.in2, bus.bin));
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    logic fi, fo;
    int   lat;
    bus.in1       = vecs[i].a;
    bus.in2       = vecs[i].b;
    bus.bin       = vecs[i].bin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step(fi, fo);
    check($sformatf("vec%0d_accept", i), {63'd0, fi}, 64'd1);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      step(fi, fo);
      if (fo && lat == 0) lat = n;
    end
    check($sformatf("vec%0d_latency", i), lat, 4);
    check($sformatf("vec%0d_value", i), {30'd0, last_bo, last_z, last_d},
          {30'd0, vecs[i].bo, vecs[i].z, vecs[i].d});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic        fi, fo;
    int          sent, recv, cnt;
    logic        pend;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd100,       32'd58,        1'b0, 32'd42,        1'b0, 1'b0};
    vecs[1] = '{32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0001_0000, 32'd1,         1'b0, 32'h0000_FFFF, 1'b0, 1'b0};
    vecs[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd0,         1'b0, 1'b1};
    vecs[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'd0,         1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{32'd0,         32'hFFFF_FFFF, 1'b1, 32'd0,         1'b1, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1,         1'b0, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    // Reset held two cycles with a valid operand presented.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in1       = $urandom;
    bus.in2       = $urandom;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_diff",      {32'd0, bus.diff},      64'd0);
    check("rst_bout",      {63'd0, bus.bout},      64'd0);
    check("rst_zero",      {63'd0, bus.zero},      64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Ten back-to-back operands with the output stalled for cycles 3..8.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 80 && (sent < 10 || q.size() != 0); c++) begin
      bus.out_ready = !(c >= 3 && c <= 8);
      bus.in_valid  = (sent < 10);
      bus.in1       = 32'h1000_0000 * sent + 32'h0101_0101;
      bus.in2       = 32'h0F0F_0F0F + sent;
      bus.bin       = sent[0];
      step(fi, fo);
      if (fi) sent++;
      if (fo) recv++;
      if (c == 4) check("bp_in_ready_drop", {63'd0, s_in_ready}, 64'd0);
      if (c == 8) check("bp_accepted_while_stalled", sent, 4);
      if (c == 8) check("bp_emitted_while_stalled", recv, 0);
    end
    check("bp_sent", sent, 10);
    check("bp_recv", recv, 10);
    bus.in_valid = 1'b0;

    // Reset with three operands in flight: none of them may come out.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in1      = $urandom;
      bus.in2      = $urandom;
      bus.bin      = 1'b0;
      bus.in_valid = 1'b1;
      step(fi, fo);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step(fi, fo);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(fi, fo);
      if (s_out_valid) cnt++;
    end
    check("midrst_no_output", cnt, 0);
    run_vec(0);

    // Random stream with random backpressure against the reference model.
    sent = 0;
    recv = 0;
    pend = 1'b0;
    ra   = '0;
    rb   = '0;
    for (int c = 0; c < 60000 && (sent < N_RAND || q.size() != 0); c++) begin
      if (!pend && sent < N_RAND) begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
          0: rb = ra;
          1: ra = 32'd0;
          2: rb = 32'hFFFF_FFFF;
          3: ra = rb + 32'd1;
          default: ;
        endcase
        bus.in1 = ra;
        bus.in2 = rb;
        bus.bin = 1'($urandom_range(0, 1));
        pend    = 1'b1;
      end
      bus.in_valid  = pend && ($urandom_range(0, 4) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(fi, fo);
      if (fi) begin
        sent++;
        pend = 1'b0;
      end
      if (fo) recv++;
    end
    check("rand_sent", sent, N_RAND);
    check("rand_recv", recv, N_RAND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
